// File: rtl/cacheline_arbiter_if.sv
// Cacheline adaptor sharing bus: I-cache port, D-cache port and the LLC-side adaptor port.
// slave = arbiter view, master = environment (caches + adaptor) view.
interface cacheline_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read_i;
    logic [ADDR_W-1:0] i_address_i;
    logic [LINE_W-1:0] i_line_o;
    logic              i_resp_o;

    logic              d_read_i;
    logic              d_write_i;
    logic [ADDR_W-1:0] d_address_i;
    logic [LINE_W-1:0] d_line_i;
    logic [LINE_W-1:0] d_line_o;
    logic              d_resp_o;

    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_address_o;
    logic [LINE_W-1:0] mem_line_o;
    logic [LINE_W-1:0] mem_line_i;
    logic              mem_resp_i;

    modport slave (
        input  i_read_i, i_address_i,
        input  d_read_i, d_write_i, d_address_i, d_line_i,
        input  mem_line_i, mem_resp_i,
        output i_line_o, i_resp_o,
        output d_line_o, d_resp_o,
        output mem_read_o, mem_write_o, mem_address_o, mem_line_o
    );

    modport master (
        output i_read_i, i_address_i,
        output d_read_i, d_write_i, d_address_i, d_line_i,
        output mem_line_i, mem_resp_i,
        input  i_line_o, i_resp_o,
        input  d_line_o, d_resp_o,
        input  mem_read_o, mem_write_o, mem_address_o, mem_line_o
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Arbitrates the single cacheline adaptor between I-cache and D-cache, one recovery cycle per transaction.
// Optional CACHELINE_ARBITER_RR_EN: round-robin tie-break instead of fixed D-over-I priority.
module cacheline_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    cacheline_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RECOVER} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;
    logic              wr_q;

    logic i_req, d_req, load, pick_d;

    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_line;
    logic              i_resp, d_resp;
    logic [LINE_W-1:0] i_line, d_line;

    assign i_req = bus.i_read_i;
    assign d_req = bus.d_read_i | bus.d_write_i;
    assign load  = (state_q == IDLE) && (i_req || d_req);

`ifdef CACHELINE_ARBITER_RR_EN
    // last_d_q = 0 means I was granted last, so D wins the first tie out of reset
    logic last_d_q;

    assign pick_d = d_req && (!i_req || !last_d_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  last_d_q <= 1'b0;
        else if (load) last_d_q <= pick_d;
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            line_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                // a simultaneous D read+write resolves to the write
                addr_q <= pick_d ? bus.d_address_i : bus.i_address_i;
                line_q <= (pick_d && bus.d_write_i) ? bus.d_line_i : '0;
                wr_q   <= pick_d && bus.d_write_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_line    = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        i_line      = '0;
        d_line      = '0;
        case (state_q)
            IDLE: begin
                if (load) state_d = pick_d ? GNT_D : GNT_I;
            end
            GNT_I: begin
                mem_read    = !wr_q;
                mem_write   = wr_q;
                mem_address = addr_q;
                mem_line    = line_q;
                if (bus.mem_resp_i) begin
                    i_resp  = 1'b1;
                    i_line  = wr_q ? '0 : bus.mem_line_i;
                    state_d = RECOVER;
                end
            end
            GNT_D: begin
                mem_read    = !wr_q;
                mem_write   = wr_q;
                mem_address = addr_q;
                mem_line    = line_q;
                if (bus.mem_resp_i) begin
                    d_resp  = 1'b1;
                    d_line  = wr_q ? '0 : bus.mem_line_i;
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_read_o    = mem_read;
    assign bus.mem_write_o   = mem_write;
    assign bus.mem_address_o = mem_address;
    assign bus.mem_line_o    = mem_line;
    assign bus.i_resp_o      = i_resp;
    assign bus.i_line_o      = i_line;
    assign bus.d_resp_o      = d_resp;
    assign bus.d_line_o      = d_line;

`ifndef SYNTHESIS
    d_op_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(bus.d_read_i && bus.d_write_i))
        else $error("cacheline_arbiter: d_read_i and d_write_i both high");
`endif

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: directed requests, adaptor model, decoupled monitor.
module tb_cacheline_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int LAT    = 4;
    localparam int TMO    = 200;
    localparam logic [LINE_W-1:0] IDLE_LINE = {8{32'hDEAD_BEEF}};
    localparam logic [LINE_W-1:0] WL1 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [LINE_W-1:0] WL2 = {4{64'hFEDC_BA98_7654_3210}};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cacheline_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();
    cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stray_req = 0;
    int stray_done = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] line;
        logic              chk_line;
        int                rise_cyc;
        int                gap;
    } exp_mem_t;
    typedef struct {
        logic              is_d;
        logic [LINE_W-1:0] line;
    } exp_resp_t;
    exp_mem_t  exp_mem[$];
    exp_resp_t exp_resp[$];

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic push_mem(input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] l,
                            input logic cl, input int rise, input int gap);
        exp_mem_t e;
        e.wr = wr; e.addr = a; e.line = l; e.chk_line = cl; e.rise_cyc = rise; e.gap = gap;
        exp_mem.push_back(e);
    endtask

    task automatic push_resp(input logic is_d, input logic [LINE_W-1:0] l);
        exp_resp_t r;
        r.is_d = is_d; r.line = l;
        exp_resp.push_back(r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"},  256'(bus.mem_read_o),    '0);
        chk({tag, "_mem_write"}, 256'(bus.mem_write_o),   '0);
        chk({tag, "_mem_addr"},  256'(bus.mem_address_o), '0);
        chk({tag, "_mem_line"},  bus.mem_line_o,          '0);
        chk({tag, "_i_resp"},    256'(bus.i_resp_o),      '0);
        chk({tag, "_d_resp"},    256'(bus.d_resp_o),      '0);
        chk({tag, "_i_line"},    bus.i_line_o,            '0);
        chk({tag, "_d_line"},    bus.d_line_o,            '0);
    endtask

    // Adaptor: returns a line derived from the address LAT cycles into the grant
    function automatic logic [LINE_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        if (a == 32'h0000_1000) return {32{8'hAA}};
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    initial begin : adaptor
        int cnt;
        cnt = 0;
        bus.mem_resp_i = 1'b0;
        bus.mem_line_i = IDLE_LINE;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_resp_i) begin
                bus.mem_resp_i = 1'b0;
                bus.mem_line_i = IDLE_LINE;
                cnt = 0;
            end else if (stray_req != stray_done) begin
                bus.mem_resp_i = 1'b1;
                stray_done = stray_req;
            end else if (reset_n && (bus.mem_read_o || bus.mem_write_o)) begin
                cnt++;
                if (cnt == LAT) begin
                    bus.mem_resp_i = 1'b1;
                    bus.mem_line_i = mem_data(bus.mem_address_o);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        logic prev_act, act;
        int last_resp;
        exp_mem_t cur;
        exp_resp_t r;
        prev_act = 1'b0;
        last_resp = -100;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_act = 1'b0;
            end else begin
                act = bus.mem_read_o || bus.mem_write_o;
                if (act && !prev_act) begin
                    if (exp_mem.size() == 0) flag("unexpected_mem_request");
                    else begin
                        cur = exp_mem.pop_front();
                        chk("mem_addr", 256'(bus.mem_address_o), 256'(cur.addr));
                        if (cur.rise_cyc >= 0) chk("req_latency", 256'(cyc), 256'(cur.rise_cyc));
                        if (cur.gap > 0) chk("idle_gap", 256'(cyc - last_resp), 256'(cur.gap));
                    end
                end
                if (act) begin
                    chk("mem_write_op", 256'(bus.mem_write_o), 256'(cur.wr));
                    chk("mem_read_op",  256'(bus.mem_read_o),  256'(!cur.wr));
                    chk("mem_addr_stable", 256'(bus.mem_address_o), 256'(cur.addr));
                    if (cur.chk_line) chk("mem_line_stable", bus.mem_line_o, cur.line);
                end
                if (bus.i_resp_o || bus.d_resp_o) begin
                    if (exp_resp.size() == 0) flag("unexpected_resp");
                    else begin
                        r = exp_resp.pop_front();
                        chk("resp_route", 256'({bus.i_resp_o, bus.d_resp_o}), r.is_d ? 256'd1 : 256'd2);
                        chk("resp_line", r.is_d ? bus.d_line_o : bus.i_line_o, r.line);
                        chk("req_held_at_resp", 256'(act), 256'd1);
                    end
                    last_resp = cyc;
                end
                if (!bus.i_resp_o) chk("i_line_idle_zero", bus.i_line_o, '0);
                if (!bus.d_resp_o) chk("d_line_idle_zero", bus.d_line_o, '0);
                prev_act = act;
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic run_i(input logic [ADDR_W-1:0] a);
        int n;
        n = 0;
        bus.i_address_i = a;
        bus.i_read_i = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.i_resp_o && n < TMO);
        if (!bus.i_resp_o) flag("i_resp_timeout");
        sync();
        bus.i_read_i = 1'b0;
    endtask

    task automatic run_d(input logic [ADDR_W-1:0] a, input logic wr, input logic [LINE_W-1:0] l);
        int n;
        n = 0;
        bus.d_address_i = a;
        bus.d_line_i = l;
        bus.d_write_i = wr;
        bus.d_read_i = !wr;
        do begin @(negedge clk); n++; end while (!bus.d_resp_o && n < TMO);
        if (!bus.d_resp_o) flag("d_resp_timeout");
        sync();
        bus.d_read_i = 1'b0;
        bus.d_write_i = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int n;
        bus.i_read_i = 1'b0; bus.i_address_i = '0;
        bus.d_read_i = 1'b0; bus.d_write_i = 1'b0;
        bus.d_address_i = '0; bus.d_line_i = '0;

        repeat (2) @(posedge clk);
        #2 chk_all_zero("reset");
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // I-only read
        sync();
        push_mem(1'b0, 32'h0000_1000, '0, 1'b0, cyc + 1, 0);
        push_resp(1'b0, {32{8'hAA}});
        run_i(32'h0000_1000);
        repeat (2) @(posedge clk);

        // D writeback
        sync();
        push_mem(1'b1, 32'h0000_2040, WL1, 1'b1, cyc + 1, 0);
        push_resp(1'b1, '0);
        run_d(32'h0000_2040, 1'b1, WL1);
        repeat (2) @(posedge clk);

        // Stray response in IDLE
        sync(); #1;
        stray_req++;
        @(posedge clk); @(negedge clk);
        chk("stray_i_resp", 256'(bus.i_resp_o), '0);
        chk("stray_d_resp", 256'(bus.d_resp_o), '0);
        chk("stray_mem_req", 256'({bus.mem_read_o, bus.mem_write_o}), '0);
        repeat (2) @(posedge clk);

        // Simultaneous I and D read from a clean grant history: D first, then I
        pulse_reset();
        sync();
        push_mem(1'b0, 32'h0000_3000, '0, 1'b0, cyc + 1, 0);
        push_mem(1'b0, 32'h0000_4000, '0, 1'b0, -1, 3);
        push_resp(1'b1, {8{32'hC0DE_3000}});
        push_resp(1'b0, {8{32'hC0DE_4000}});
        fork
            run_d(32'h0000_3000, 1'b0, '0);
            run_i(32'h0000_4000);
        join
        repeat (2) @(posedge clk);

        // Reset during a D write grant
        sync();
        push_mem(1'b1, 32'h0000_5000, WL2, 1'b1, cyc + 1, 0);
        bus.d_address_i = 32'h0000_5000; bus.d_line_i = WL2; bus.d_write_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.mem_write_o && n < TMO);
        if (!bus.mem_write_o) flag("mid_grant_write_timeout");
        #2 reset_n = 1'b0;
        #1 chk_all_zero("reset_mid");
        bus.d_write_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        sync();
        push_mem(1'b0, 32'h0000_6000, '0, 1'b0, cyc + 1, 0);
        push_resp(1'b0, {8{32'hC0DE_6000}});
        run_i(32'h0000_6000);
        repeat (2) @(posedge clk);

        // Both caches requesting continuously for four transactions
        sync();
`ifdef CACHELINE_ARBITER_RR_EN
        push_mem(1'b0, 32'h0000_7000, '0, 1'b0, cyc + 1, 0); push_resp(1'b1, {8{32'hC0DE_7000}});
        push_mem(1'b0, 32'h0000_8000, '0, 1'b0, -1, 3);      push_resp(1'b0, {8{32'hC0DE_8000}});
        push_mem(1'b0, 32'h0000_7040, '0, 1'b0, -1, 3);      push_resp(1'b1, {8{32'hC0DE_7040}});
        push_mem(1'b0, 32'h0000_8040, '0, 1'b0, -1, 3);      push_resp(1'b0, {8{32'hC0DE_8040}});
`else
        push_mem(1'b0, 32'h0000_7000, '0, 1'b0, cyc + 1, 0); push_resp(1'b1, {8{32'hC0DE_7000}});
        push_mem(1'b0, 32'h0000_7040, '0, 1'b0, -1, 3);      push_resp(1'b1, {8{32'hC0DE_7040}});
        push_mem(1'b0, 32'h0000_8000, '0, 1'b0, -1, 3);      push_resp(1'b0, {8{32'hC0DE_8000}});
        push_mem(1'b0, 32'h0000_8040, '0, 1'b0, -1, 3);      push_resp(1'b0, {8{32'hC0DE_8040}});
`endif
        fork
            begin run_d(32'h0000_7000, 1'b0, '0); run_d(32'h0000_7040, 1'b0, '0); end
            begin run_i(32'h0000_8000); run_i(32'h0000_8040); end
        join

        repeat (4) @(posedge clk);
        chk("exp_mem_drained",  256'(exp_mem.size()),  '0);
        chk("exp_resp_drained", 256'(exp_resp.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
